// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard-detection inputs and stage-control outputs of the pipeline hazard controller
interface pipeline_hazard_controller_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memory_read_enable;
    logic        mem_branch;
    logic        mem_zero;
    logic        mem_pc_update;
    logic        mem_memory_read_enable;
    logic        mem_memory_write_enable;
    logic        dmem_ready;
    logic        pc_write_enable;
    logic        if_id_write_enable;
    logic        id_ex_write_enable;
    logic        ex_mem_write_enable;
    logic        mem_wb_write_enable;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        pc_redirect;
    logic        dmem_request;
    logic        memory_fault;
    logic [31:0] stall_cycle_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memory_read_enable,
               mem_branch, mem_zero, mem_pc_update, mem_memory_read_enable,
               mem_memory_write_enable, dmem_ready,
        input  pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable,
               mem_wb_write_enable, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_redirect, dmem_request, memory_fault, stall_cycle_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memory_read_enable,
               mem_branch, mem_zero, mem_pc_update, mem_memory_read_enable,
               mem_memory_write_enable, dmem_ready,
        output pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable,
               mem_wb_write_enable, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_redirect, dmem_request, memory_fault, stall_cycle_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/redirect control for a 5-stage pipeline with a variable-latency data memory
module pipeline_hazard_controller #(
    parameter int MEMORY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_controller_if.slave  hz
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_count_q, wait_count_d;
    logic        memory_fault_q, memory_fault_d;
    logic [31:0] stall_cycle_count_q, stall_cycle_count_d;
    logic        mem_access, redirect, load_use;
    logic        timeout, mem_stall, take_redirect, load_use_stall, pc_we;

    assign mem_access = hz.mem_memory_read_enable | hz.mem_memory_write_enable;
    assign redirect   = hz.mem_pc_update | (hz.mem_branch & hz.mem_zero);
    assign load_use   = hz.ex_memory_read_enable & (hz.ex_rd != 5'd0) &
                        ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                         (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

    // Priority chain: memory stall, then redirect (only when the pipeline advances), then load-use bubble
    assign timeout        = (state_q == MEM_WAIT) & ~hz.dmem_ready & (wait_count_q == 8'(MEMORY_TIMEOUT - 1));
    assign mem_stall      = ~hz.dmem_ready & ((state_q == RUN) ? mem_access : ~timeout);
    assign take_redirect  = redirect & ~mem_stall & ~timeout;
    assign load_use_stall = load_use & ~mem_stall & ~take_redirect;
    assign pc_we          = ~mem_stall & ~load_use_stall;

    // State and counters; reset abandons any outstanding memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= RUN;
            wait_count_q        <= 8'd0;
            memory_fault_q      <= 1'b0;
            stall_cycle_count_q <= 32'd0;
        end else begin
            state_q             <= state_d;
            wait_count_q        <= wait_count_d;
            memory_fault_q      <= memory_fault_d;
            stall_cycle_count_q <= stall_cycle_count_d;
        end
    end

    // Next state: stay in MEM_WAIT while the memory stall persists; fault is sticky; stall count saturates
    always_comb begin
        state_d             = mem_stall ? MEM_WAIT : RUN;
        wait_count_d        = mem_stall ? wait_count_q + 8'd1 : 8'd0;
        memory_fault_d      = memory_fault_q | timeout;
        stall_cycle_count_d = (~pc_we & ~&stall_cycle_count_q) ? stall_cycle_count_q + 32'd1 : stall_cycle_count_q;
    end

    // Stage controls; request and redirect are forced low while reset is asserted
    always_comb begin
        hz.pc_write_enable     = pc_we;
        hz.if_id_write_enable  = pc_we;
        hz.id_ex_write_enable  = ~mem_stall;
        hz.ex_mem_write_enable = ~mem_stall;
        hz.mem_wb_write_enable = ~mem_stall;
        hz.if_id_flush         = take_redirect;
        hz.id_ex_flush         = take_redirect | load_use_stall;
        hz.ex_mem_flush        = take_redirect;
        hz.mem_wb_flush        = timeout;
        hz.pc_redirect         = rst_n & take_redirect;
        hz.dmem_request        = rst_n & ((state_q == MEM_WAIT) | mem_access);
        hz.memory_fault        = memory_fault_q;
        hz.stall_cycle_count   = stall_cycle_count_q;
    end
endmodule
